accel_ctrl_master: RTL and testbench
====================================

# accel_ctrl_master

AXI-Lite initiator that drives the accelerator core control register map on behalf of a host-side sequencer. It accepts single-beat commands (write, read, or poll-until-match) on a valid/ready command port and runs the AW/W/B or AR/R channel handshakes on an `Axi.Master` port. It returns one registered response per command. It sits between the control sequencer and the core-control AXI-Lite slave, and is used to program the register map and to wait on the buffer full/empty status registers.

## Interface
Parameters:
- `ADDR_W`, 32: AXI address width.
- `DATA_W`, `accel_core_pkg::MMAP_WIDTH`: data width.
- `POLL_MAX`, 1024: maximum poll reads per poll command; must be ≥1.
- `POLL_GAP`, 8: idle cycles between poll reads; 0 is legal.

Ports:
- `aclk` in 1: clock. The parent ties this to `core_ctrl.aclk`.
- `aresetn` in 1: reset, asynchronous, active-low. The parent ties this to `core_ctrl.aresetn`.
- `core_ctrl` `Axi.Master`: AXI-Lite channels AW, W, B, AR, R.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: `accel_core_pkg::ctrl_op_e` (OP_WR=0, OP_RD=1, OP_POLL=2; 3 is treated as OP_RD).
- `cmd_addr` in `ADDR_W`: target address.
- `cmd_wdata` in `DATA_W`: write data (OP_WR) or expected value (OP_POLL).
- `cmd_mask` in `DATA_W`: compare mask (OP_POLL only).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out `DATA_W`: last read data (0 for writes).
- `rsp_status` out 2: `accel_core_pkg::ctrl_status_e` (ST_OK=0, ST_SLVERR=1, ST_POLL_FAIL=2).
- `rsp_polls` out `$clog2(POLL_MAX+1)`: number of poll reads issued.

## Operation
- FSM states (`ctrl_state_e`): IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, POLL_WAIT, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On the cmd handshake, latch all cmd fields, clear the poll counter, and go to WR_REQ (OP_WR) or RD_REQ (other ops).
- WR_REQ:
  - Assert `awvalid` and `wvalid` together with `awaddr`/`wdata` stable and `wstrb` all ones.
  - Drop each valid independently on its own handshake (track `aw_done` and `w_done`).
  - When both are done, go to WR_RESP.
- WR_RESP:
  - `bready`=1.
  - On `bvalid`, status = (`bresp`≠0) ? ST_SLVERR : ST_OK; go to RSP.
- RD_REQ:
  - `arvalid`=1 and `rready`=1. `rready` is asserted together with `arvalid` because the slave qualifies `rvalid` on `rready` in the address cycle.
  - On the AR handshake, go to RD_RESP. If `rvalid` arrives in the same cycle as the AR handshake, accept it and go straight to the RD_RESP exit actions.
- RD_RESP:
  - `rready`=1.
  - On `rvalid`, latch `rdata`.
  - `rresp`≠0 → ST_SLVERR, go to RSP. This ends a poll immediately.
  - OP_RD → ST_OK, go to RSP.
  - OP_POLL: increment the poll counter.
    - If (`rdata` & mask) == (expected & mask) → ST_OK, go to RSP.
    - Else if count == `POLL_MAX` → ST_POLL_FAIL, go to RSP.
    - Else go to POLL_WAIT.
- POLL_WAIT: count `POLL_GAP` cycles, then go to RD_REQ. With `POLL_GAP`=0, go to RD_REQ on the next cycle.
- RSP:
  - `rsp_valid`=1, with all `rsp_*` fields held stable.
  - On `rsp_ready`, go to IDLE.
- All AXI valids are registered outputs.
- Once raised, a valid is never dropped before its ready.
- Address and data are stable while valid is high.

## Timing
- Reset values: all AXI valids/readies = 0, `awaddr`/`araddr`/`wdata` = 0, `wstrb` = 0, `cmd_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_status` = ST_OK, `rsp_polls` = 0, state = IDLE.
- `cmd_ready` rises on the first clock edge after `aresetn` deasserts.
- Command accepted at edge N → AXI valid high during cycle N+1.
- Minimum latency, with the slave always ready and responding after one cycle:
  - write: `rsp_valid` at N+3.
  - read: `rsp_valid` at N+3.
- Each additional poll iteration adds `POLL_GAP` + 2 cycles.
- Reset mid-transaction: all outputs return to reset values immediately. The in-flight command is lost and no response is produced.
- No command pipelining: one outstanding command at a time.

## Structure
- Add to `accel_core_pkg`: `ctrl_op_e`, `ctrl_status_e`, `ctrl_state_e`, and the constant `AXI_RESP_OKAY`.
- Single module with the poll and gap counters inline. No sub-module is needed.

## Test plan
- Write of `0x0000_00A5` to address 0, slave always ready → AW and W handshake in the same cycle, `bresp`=0 → `rsp_valid` at N+3 with ST_OK and `rsp_rdata`=0.
- Slave delays `wready` 3 cycles after `awready` → `awvalid` drops after its own handshake, `wvalid` is held with stable data, exactly one write occurs, ST_OK.
- Write to a read-only address, slave returns `bresp`=1 → ST_SLVERR, `rsp_valid` held until `rsp_ready` is asserted 5 cycles later.
- Read of address 2 returning `0x1234` → `rsp_rdata`=`0x1234`, ST_OK. `rready` was high in the `arvalid` cycle.
- Poll with mask=1, expected=1; slave returns 0, 0, 1 → `rsp_polls`=3, ST_OK. Gap between the two `arvalid` assertions = `POLL_GAP` cycles.
- Poll that never matches with `POLL_MAX`=4 → exactly 4 AR handshakes, `rsp_polls`=4, ST_POLL_FAIL. Assert `aresetn` low mid-poll in a repeat run → all outputs return to reset values immediately and no response is produced.

Source files
------------

// File: rtl/accel_core_pkg.sv
// accel_core_pkg: shared types and constants for the accelerator core control path.
//   MMAP_WIDTH    : width of the memory-mapped control registers
//   AXI_RESP_OKAY : AXI response code for a successful transfer
//   ctrl_op_e     : command opcodes accepted by accel_ctrl_master
//   ctrl_status_e : completion status returned with each response
//   ctrl_state_e  : accel_ctrl_master FSM states
package accel_core_pkg;

    localparam int MMAP_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        OP_WR   = 2'd0,
        OP_RD   = 2'd1,
        OP_POLL = 2'd2
    } ctrl_op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_SLVERR    = 2'd1,
        ST_POLL_FAIL = 2'd2
    } ctrl_status_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_REQ    = 3'd1,
        WR_RESP   = 3'd2,
        RD_REQ    = 3'd3,
        RD_RESP   = 3'd4,
        POLL_WAIT = 3'd5,
        RSP       = 3'd6
    } ctrl_state_e;

endpackage

// File: rtl/axi_if.sv
// Axi: AXI-Lite channel bundle (AW, W, B, AR, R).
//   Master modport : drives valids/addresses/data and the B/R readies,
//                    observes the slave readies and responses.
interface Axi #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport Master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/accel_ctrl_master.sv
// accel_ctrl_master: single-outstanding AXI-Lite initiator for the core
// control register map. Executes write, read and poll-until-match commands.
//   aclk, aresetn          : clock, asynchronous active-low reset
//   core_ctrl              : AXI-Lite master channels
//   cmd_valid/cmd_ready    : command handshake (ready only while idle)
//   cmd_op/addr/wdata/mask : opcode, address, write data or expected value, poll mask
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata/status/polls : last read data, completion status, poll reads issued
module accel_ctrl_master
    import accel_core_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = MMAP_WIDTH,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 8,
    localparam int CNT_W   = $clog2(POLL_MAX + 1),
    localparam int GAP_W   = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    Axi.Master                 core_ctrl,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  ctrl_op_e           cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    input  logic [DATA_W-1:0]  cmd_mask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output ctrl_status_e       rsp_status,
    output logic [CNT_W-1:0]   rsp_polls
);

    ctrl_state_e        state;
    ctrl_state_e        state_nxt;
    ctrl_op_e           op_q;
    logic [DATA_W-1:0]  exp_q;
    logic [DATA_W-1:0]  mask_q;
    logic               aw_done;
    logic               w_done;
    logic               aw_done_nxt;
    logic               w_done_nxt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               cmd_fire;
    logic               ar_hs;
    logic               b_hs;
    logic               rd_beat;
    logic               poll_match;
    logic               poll_last;
    logic               gap_last;
    logic               rd_end;
    ctrl_status_e       rd_status;

    assign cmd_fire   = cmd_valid & cmd_ready;
    assign ar_hs      = core_ctrl.arvalid & core_ctrl.arready;
    assign b_hs       = core_ctrl.bvalid & core_ctrl.bready;
    // A read beat counts in RD_RESP, or in RD_REQ when the slave returns
    // data in the same cycle it accepts the address.
    assign rd_beat    = core_ctrl.rvalid & core_ctrl.rready &
                        ((state == RD_RESP) | ((state == RD_REQ) & ar_hs));
    assign poll_match = ((core_ctrl.rdata & mask_q) == (exp_q & mask_q));
    assign poll_last  = (rsp_polls + CNT_W'(1)) == CNT_W'(POLL_MAX);
    assign gap_last   = (int'(gap_cnt) == POLL_GAP - 1);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done | (core_ctrl.awvalid & core_ctrl.awready);
        w_done_nxt  = w_done  | (core_ctrl.wvalid  & core_ctrl.wready);
        rd_end      = 1'b0;
        rd_status   = ST_OK;

        // Outcome of a read beat; an error response ends a poll at once.
        if (core_ctrl.rresp != AXI_RESP_OKAY) begin
            rd_end    = 1'b1;
            rd_status = ST_SLVERR;
        end else if ((op_q != OP_POLL) || poll_match) begin
            rd_end    = 1'b1;
        end else if (poll_last) begin
            rd_end    = 1'b1;
            rd_status = ST_POLL_FAIL;
        end

        case (state)
            IDLE:      if (cmd_fire) state_nxt = (cmd_op == OP_WR) ? WR_REQ : RD_REQ;
            WR_REQ:    if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
            WR_RESP:   if (b_hs) state_nxt = RSP;
            RD_REQ, RD_RESP: begin
                if (rd_beat) begin
                    if (rd_end)             state_nxt = RSP;
                    else if (POLL_GAP == 0) state_nxt = RD_REQ;
                    else                    state_nxt = POLL_WAIT;
                end else if ((state == RD_REQ) && ar_hs) begin
                    state_nxt = RD_RESP;
                end
            end
            POLL_WAIT: if (gap_last) state_nxt = RD_REQ;
            RSP:       if (rsp_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Registered outputs and command context
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_ready         <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_rdata         <= '0;
            rsp_status        <= ST_OK;
            rsp_polls         <= '0;
            core_ctrl.awvalid <= 1'b0;
            core_ctrl.awaddr  <= '0;
            core_ctrl.wvalid  <= 1'b0;
            core_ctrl.wdata   <= '0;
            core_ctrl.wstrb   <= '0;
            core_ctrl.bready  <= 1'b0;
            core_ctrl.arvalid <= 1'b0;
            core_ctrl.araddr  <= '0;
            core_ctrl.rready  <= 1'b0;
            op_q              <= OP_WR;
            exp_q             <= '0;
            mask_q            <= '0;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            gap_cnt           <= '0;
        end else begin
            cmd_ready         <= (state_nxt == IDLE);
            rsp_valid         <= (state_nxt == RSP);
            core_ctrl.awvalid <= (state_nxt == WR_REQ) && !aw_done_nxt;
            core_ctrl.wvalid  <= (state_nxt == WR_REQ) && !w_done_nxt;
            core_ctrl.bready  <= (state_nxt == WR_RESP);
            core_ctrl.arvalid <= (state_nxt == RD_REQ);
            // rready rides along with arvalid: the slave only raises rvalid
            // when it sees rready during the address cycle.
            core_ctrl.rready  <= (state_nxt == RD_REQ) || (state_nxt == RD_RESP);
            aw_done           <= (state_nxt == WR_REQ) ? aw_done_nxt : 1'b0;
            w_done            <= (state_nxt == WR_REQ) ? w_done_nxt  : 1'b0;
            gap_cnt           <= (state == POLL_WAIT) ? gap_cnt + GAP_W'(1) : '0;

            if (cmd_fire) begin
                op_q       <= cmd_op;
                exp_q      <= cmd_wdata;
                mask_q     <= cmd_mask;
                rsp_polls  <= '0;
                rsp_rdata  <= '0;
                rsp_status <= ST_OK;
                if (cmd_op == OP_WR) begin
                    core_ctrl.awaddr <= cmd_addr;
                    core_ctrl.wdata  <= cmd_wdata;
                    core_ctrl.wstrb  <= '1;
                end else begin
                    core_ctrl.araddr <= cmd_addr;
                end
            end

            if ((state == WR_RESP) && b_hs) begin
                rsp_status <= (core_ctrl.bresp != AXI_RESP_OKAY) ? ST_SLVERR : ST_OK;
            end

            if (rd_beat) begin
                rsp_rdata <= core_ctrl.rdata;
                if (op_q == OP_POLL) rsp_polls <= rsp_polls + CNT_W'(1);
                if (rd_end) rsp_status <= rd_status;
            end
        end
    end

endmodule

// File: tb/tb_accel_ctrl_master.sv
// tb_accel_ctrl_master: directed self-checking bench for accel_ctrl_master.
// The AXI-Lite slave is played by each test task, cycle by cycle, on the
// falling clock edge; DUT outputs are sampled on the same falling edge.
module tb_accel_ctrl_master;
    import accel_core_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int PMAX = 4;
    localparam int PGAP = 2;
    localparam int CW   = $clog2(PMAX + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    ctrl_op_e      cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    ctrl_status_e  rsp_status;
    logic [CW-1:0] rsp_polls;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    Axi #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    accel_ctrl_master #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .POLL_MAX (PMAX),
        .POLL_GAP (PGAP)
    ) dut (
        .aclk       (clk),
        .aresetn    (rst_n),
        .core_ctrl  (axi),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_mask   (cmd_mask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .rsp_polls  (rsp_polls)
    );

    // Presents a command at a falling edge and returns at the falling edge of
    // cycle N+1, where N is the rising edge that accepted it.
    task automatic issue(input ctrl_op_e op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] mask);
        int k;
        cmd_op = op; cmd_addr = addr; cmd_wdata = data; cmd_mask = mask;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_accept: cmd_ready=%b expected 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic slave_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;   axi.rresp = 2'b00;
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = OP_WR; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        rsp_ready = 1'b0;
        slave_idle();
        repeat (3) @(negedge clk);
        ctl = {cmd_ready, rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready};
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected 0000000", ctl);
        end
        checks++;
        if (axi.awaddr !== '0 || axi.araddr !== '0 || axi.wdata !== '0 || axi.wstrb !== 4'h0) begin
            failures++;
            $display("FAIL reset_axi_data: awaddr=%h araddr=%h wdata=%h wstrb=%h expected all 0",
                     axi.awaddr, axi.araddr, axi.wdata, axi.wstrb);
        end
        checks++;
        if (rsp_rdata !== '0 || rsp_status !== ST_OK || rsp_polls !== '0) begin
            failures++;
            $display("FAIL reset_rsp: rdata=%h status=%0d polls=%0d expected 0/0/0",
                     rsp_rdata, rsp_status, rsp_polls);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 0 before first edge", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        axi.awready = 1'b1; axi.wready = 1'b1;
        issue(OP_WR, 32'h0, 32'h0000_00A5, 32'h0);
        checks++;
        if ({axi.awvalid, axi.wvalid} !== 2'b11) begin
            failures++;
            $display("FAIL wr_valids_n1: aw/w=%b expected 11", {axi.awvalid, axi.wvalid});
        end
        checks++;
        if (axi.awaddr !== 32'h0 || axi.wdata !== 32'hA5 || axi.wstrb !== 4'hF) begin
            failures++;
            $display("FAIL wr_payload: awaddr=%h wdata=%h wstrb=%h expected 0/a5/f",
                     axi.awaddr, axi.wdata, axi.wstrb);
        end
        @(negedge clk);
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready, rsp_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL wr_n2: aw/w/bready/rsp=%b expected 0010",
                     {axi.awvalid, axi.wvalid, axi.bready, rsp_valid});
        end
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        @(negedge clk);
        axi.bvalid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_rsp_latency: rsp_valid=%b at N+3 expected 1", rsp_valid);
        end
        checks++;
        if (rsp_status !== ST_OK || rsp_rdata !== '0) begin
            failures++;
            $display("FAIL wr_rsp_fields: status=%0d rdata=%h expected 0/0", rsp_status, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_rsp_release: rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read();
        axi.arready = 1'b1;
        issue(OP_RD, 32'h2, 32'h0, 32'h0);
        checks++;
        if ({axi.arvalid, axi.rready} !== 2'b11 || axi.araddr !== 32'h2) begin
            failures++;
            $display("FAIL rd_addr_cycle: arvalid/rready=%b araddr=%h expected 11/2",
                     {axi.arvalid, axi.rready}, axi.araddr);
        end
        @(negedge clk);
        axi.arready = 1'b0;
        checks++;
        if ({axi.arvalid, axi.rready, rsp_valid} !== 3'b010) begin
            failures++;
            $display("FAIL rd_n2: arvalid/rready/rsp=%b expected 010", {axi.arvalid, axi.rready, rsp_valid});
        end
        axi.rvalid = 1'b1; axi.rdata = 32'h1234; axi.rresp = 2'b00;
        @(negedge clk);
        axi.rvalid = 1'b0; axi.rdata = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234 || rsp_status !== ST_OK) begin
            failures++;
            $display("FAIL rd_rsp: valid=%b rdata=%h status=%0d expected 1/1234/0",
                     rsp_valid, rsp_rdata, rsp_status);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_wready_delay();
        int aw_n = 0;
        int w_n = 0;
        bit unstable = 0;
        axi.awready = 1'b1; axi.wready = 1'b0;
        issue(OP_WR, 32'h10, 32'hDEAD_BEEF, 32'h0);
        for (int k = 0; k < 20; k++) begin
            if (axi.bready) break;
            if (k == 1) begin
                checks++;
                if ({axi.awvalid, axi.wvalid} !== 2'b01) begin
                    failures++;
                    $display("FAIL aw_drop_w_hold: aw/w=%b expected 01", {axi.awvalid, axi.wvalid});
                end
            end
            if (k == 3) axi.wready = 1'b1;
            if (axi.wvalid && (axi.wdata !== 32'hDEAD_BEEF || axi.awaddr !== 32'h10)) unstable = 1;
            if (axi.awvalid && axi.awready) aw_n++;
            if (axi.wvalid && axi.wready) w_n++;
            @(negedge clk);
        end
        axi.awready = 1'b0; axi.wready = 1'b0;
        checks++;
        if (axi.bready !== 1'b1) begin
            failures++;
            $display("FAIL wdly_timeout: bready=%b expected 1", axi.bready);
        end
        checks++;
        if (aw_n != 1 || w_n != 1) begin
            failures++;
            $display("FAIL wdly_beats: aw=%0d w=%0d expected 1/1", aw_n, w_n);
        end
        checks++;
        if (unstable) begin
            failures++;
            $display("FAIL wdly_stable: wdata/awaddr changed while valid, expected deadbeef/10");
        end
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        @(negedge clk);
        axi.bvalid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== ST_OK || rsp_rdata !== '0) begin
            failures++;
            $display("FAIL wdly_rsp: valid=%b status=%0d rdata=%h expected 1/0/0",
                     rsp_valid, rsp_status, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_slverr();
        bit dropped = 0;
        axi.awready = 1'b1; axi.wready = 1'b1;
        issue(OP_WR, 32'h44, 32'h55, 32'h0);
        for (int k = 0; k < 20 && !axi.bready; k++) @(negedge clk);
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b1; axi.bresp = 2'b01;
        @(negedge clk);
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== ST_SLVERR) begin
            failures++;
            $display("FAIL slverr_rsp: valid=%b status=%0d expected 1/1", rsp_valid, rsp_status);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_status !== ST_SLVERR) dropped = 1;
        end
        checks++;
        if (dropped) begin
            failures++;
            $display("FAIL slverr_hold: rsp dropped or changed before rsp_ready, expected held 1/1");
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL slverr_release: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    // The slave accepts AR and returns R in the same cycle, so the arvalid-low
    // run between two reads is exactly the POLL_WAIT interval.
    task automatic test_poll_match();
        int ar_n = 0;
        int low = 0;
        int gap[2] = '{-1, -1};
        issue(OP_POLL, 32'h20, 32'h1, 32'h1);
        for (int k = 0; k < 100; k++) begin
            if (rsp_valid) break;
            if (axi.arvalid) begin
                if (ar_n > 0 && ar_n < 3) gap[ar_n-1] = low;
                low = 0;
                axi.arready = 1'b1; axi.rvalid = 1'b1;
                axi.rdata = (ar_n == 2) ? 32'h1 : 32'h0;
                ar_n++;
            end else begin
                axi.arready = 1'b0; axi.rvalid = 1'b0;
                low++;
            end
            @(negedge clk);
        end
        slave_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== ST_OK || rsp_polls !== 3'd3 || rsp_rdata !== 32'h1) begin
            failures++;
            $display("FAIL poll_match_rsp: valid=%b status=%0d polls=%0d rdata=%h expected 1/0/3/1",
                     rsp_valid, rsp_status, rsp_polls, rsp_rdata);
        end
        checks++;
        if (ar_n != 3) begin
            failures++;
            $display("FAIL poll_match_reads: ar=%0d expected 3", ar_n);
        end
        checks++;
        if (gap[0] != PGAP || gap[1] != PGAP) begin
            failures++;
            $display("FAIL poll_gap: gaps=%0d,%0d expected %0d,%0d", gap[0], gap[1], PGAP, PGAP);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_poll_fail();
        int ar_n = 0;
        issue(OP_POLL, 32'h24, 32'h1, 32'h1);
        for (int k = 0; k < 100; k++) begin
            if (rsp_valid) break;
            axi.arready = axi.arvalid; axi.rvalid = axi.arvalid; axi.rdata = 32'h0;
            if (axi.arvalid) ar_n++;
            @(negedge clk);
        end
        slave_idle();
        checks++;
        if (ar_n != PMAX) begin
            failures++;
            $display("FAIL poll_fail_reads: ar=%0d expected %0d", ar_n, PMAX);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== ST_POLL_FAIL || rsp_polls !== 3'd4) begin
            failures++;
            $display("FAIL poll_fail_rsp: valid=%b status=%0d polls=%0d expected 1/2/4",
                     rsp_valid, rsp_status, rsp_polls);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_poll();
        int ar_n = 0;
        bit spurious = 0;
        logic [6:0] ctl;
        issue(OP_POLL, 32'h30, 32'h1, 32'h1);
        for (int k = 0; k < 40; k++) begin
            if (ar_n == 2) break;
            axi.arready = axi.arvalid; axi.rvalid = axi.arvalid; axi.rdata = 32'h0;
            if (axi.arvalid) ar_n++;
            @(negedge clk);
        end
        slave_idle();
        rst_n = 1'b0;
        #1;
        ctl = {cmd_ready, rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready};
        checks++;
        if (ctl !== 7'b0) begin
            failures++;
            $display("FAIL midrst_ctl: got %b expected 0000000", ctl);
        end
        checks++;
        if (axi.araddr !== '0 || axi.awaddr !== '0 || axi.wdata !== '0 || axi.wstrb !== 4'h0) begin
            failures++;
            $display("FAIL midrst_axi_data: araddr=%h awaddr=%h wdata=%h wstrb=%h expected all 0",
                     axi.araddr, axi.awaddr, axi.wdata, axi.wstrb);
        end
        checks++;
        if (rsp_polls !== '0 || rsp_status !== ST_OK || rsp_rdata !== '0) begin
            failures++;
            $display("FAIL midrst_rsp: polls=%0d status=%0d rdata=%h expected 0/0/0",
                     rsp_polls, rsp_status, rsp_rdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || axi.arvalid !== 1'b0) spurious = 1;
        end
        checks++;
        if (spurious || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after: spurious=%0d cmd_ready=%b expected 0/1", spurious, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read();
        test_write_wready_delay();
        test_write_slverr();
        test_poll_match();
        test_poll_fail();
        test_reset_mid_poll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
